// File: rtl/pwm_capture.sv
// pwm_capture: measures high time and period of an asynchronous PWM input, in CLK cycles.
// Two-flop synchroniser, glitch filter, rise detector and a two-state measurement FSM with stuck-line timeout.
module pwm_capture #(
  parameter int CNT_W    = 16,
  parameter int FILT_LEN = 3
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             PWM_IN,
  output logic [CNT_W-1:0] HIGH_CNT,
  output logic [CNT_W-1:0] PERIOD_CNT,
  output logic             VALID,
  output logic             TIMEOUT,
  output logic             STUCK_LVL
);

  localparam logic [0:0]       ST_WAIT_RISE = 1'b0;
  localparam logic [0:0]       ST_MEAS      = 1'b1;
  localparam logic [3:0]       FILT_LAST    = 4'(FILT_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             r_sync1;
  logic             r_sync2;
  logic             r_filt_lvl;
  logic             r_filt_d;
  logic [3:0]       r_fcnt;
  logic [0:0]       r_state;
  logic [CNT_W-1:0] r_per_cnt;
  logic [CNT_W-1:0] r_hi_cnt;
  logic [CNT_W-1:0] r_high_cnt;
  logic [CNT_W-1:0] r_period_cnt;
  logic             r_valid;
  logic             r_timeout;
  logic             r_stuck_lvl;
  logic             w_rise;

  // NOTE: every register uses non-blocking assignment and clears in the async reset branch,
  // so all flops update together from pre-edge values regardless of block order.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_filt_lvl <= 1'b0;
      r_filt_d   <= 1'b0;
      r_fcnt     <= 4'd0;
    end else begin
      r_sync1  <= PWM_IN;
      r_sync2  <= r_sync1;
      r_filt_d <= r_filt_lvl;
      // A new level is accepted only after FILT_LEN consecutive differing samples.
      if (r_sync2 == r_filt_lvl) begin
        r_fcnt <= 4'd0;
      end else if (r_fcnt == FILT_LAST) begin
        r_filt_lvl <= r_sync2;
        r_fcnt     <= 4'd0;
      end else begin
        r_fcnt <= r_fcnt + 4'd1;
      end
    end
  end

  assign w_rise = r_filt_lvl & ~r_filt_d;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state      <= ST_WAIT_RISE;
      r_per_cnt    <= '0;
      r_hi_cnt     <= '0;
      r_high_cnt   <= '0;
      r_period_cnt <= '0;
      r_valid      <= 1'b0;
      r_timeout    <= 1'b0;
      r_stuck_lvl  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (r_state == ST_MEAS) begin
        // A rise coinciding with saturation is reported, not timed out.
        if (w_rise) begin
          r_high_cnt   <= r_hi_cnt;
          r_period_cnt <= r_per_cnt;
          r_valid      <= 1'b1;
          r_timeout    <= 1'b0;
          r_per_cnt    <= CNT_ONE;
          r_hi_cnt     <= CNT_ONE;
        end else if (r_per_cnt == CNT_MAX) begin
          r_timeout   <= 1'b1;
          r_stuck_lvl <= r_filt_lvl;
          r_state     <= ST_WAIT_RISE;
        end else begin
          r_per_cnt <= r_per_cnt + CNT_ONE;
          r_hi_cnt  <= r_hi_cnt + {{(CNT_W-1){1'b0}}, r_filt_lvl};
        end
      end else if (w_rise) begin
        r_per_cnt <= CNT_ONE;
        r_hi_cnt  <= CNT_ONE;
        r_state   <= ST_MEAS;
      end
    end
  end

  assign HIGH_CNT   = r_high_cnt;
  assign PERIOD_CNT = r_period_cnt;
  assign VALID      = r_valid;
  assign TIMEOUT    = r_timeout;
  assign STUCK_LVL  = r_stuck_lvl;

endmodule
